pipe_reg_hs: RTL and testbench

Parametrised pipeline register with a valid/ready handshake, synchronous flush and an optional skid entry. It generalises the single-bit write-enabled flop to a WIDTH-bit stage whose enable comes from the handshake. It is the standard inter-stage register between core pipeline stages (fetch→decode, decode→dispatch, issue→execute). With SKID=1 it breaks the combinational ready path between stages.

---
 rtl/pipe_reg_hs.sv | 118 +++++++++++
 tb/tb_pipe_reg_hs.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_reg_hs.sv
// Inter-stage pipeline register with valid/ready handshake, synchronous flush
// and an optional skid entry that registers in_ready for timing isolation.
module pipe_reg_hs #(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter bit               SKID    = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occ
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             main_v;
    logic             skid_v;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] skid_d;
    logic             rdy_q;
    logic             rdy_nxt;
    logic             accept;
    logic             drain;
    logic             ld_main_in;
    logic             ld_main_skid;
    logic             ld_skid;

    assign main_v    = (state != S_EMPTY);
    assign skid_v    = (state == S_TWO);
    assign out_valid = main_v;
    assign out_data  = main_d;
    assign occ       = 2'(main_v) + 2'(skid_v);

    // The skid variant sources in_ready from a flop so out_ready never reaches it.
    generate
        if (SKID) begin : g_skid_ready
            assign in_ready = rdy_q & ~rst;
        end else begin : g_comb_ready
            assign in_ready = rst | ~main_v | out_ready;
        end
    endgenerate

    assign accept = in_valid & in_ready;
    assign drain  = out_valid & out_ready;

    always_comb begin
        state_nxt    = state;
        ld_main_in   = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid      = 1'b0;
        case (state)
            S_EMPTY: begin
                if (accept) begin
                    state_nxt  = S_ONE;
                    ld_main_in = 1'b1;
                end
            end
            S_ONE: begin
                if (accept && drain) begin
                    ld_main_in = 1'b1;
                end else if (accept) begin
                    // Without a skid entry in_ready already implies a drain here.
                    if (SKID) begin
                        state_nxt = S_TWO;
                        ld_skid   = 1'b1;
                    end else begin
                        ld_main_in = 1'b1;
                    end
                end else if (drain) begin
                    state_nxt = S_EMPTY;
                end
            end
            S_TWO: begin
                if (drain) begin
                    state_nxt    = S_ONE;
                    ld_main_skid = 1'b1;
                end
            end
            default: begin
                state_nxt = S_EMPTY;
            end
        endcase
        rdy_nxt = (state_nxt != S_TWO);
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state  <= S_EMPTY;
            rdy_q  <= 1'b1;
            main_d <= RST_VAL;
            skid_d <= RST_VAL;
        end else begin
            state <= state_nxt;
            rdy_q <= rdy_nxt;
            if (ld_main_in) begin
                main_d <= in_data;
            end else if (ld_main_skid) begin
                main_d <= skid_d;
            end
            if (ld_skid) begin
                skid_d <= in_data;
            end
        end
    end

endmodule

// File: tb/tb_pipe_reg_hs.sv
// Bench for pipe_reg_hs: one skid and one non-skid instance checked each cycle
// against a FIFO-queue reference model, with directed steps then random traffic.
module tb_pipe_reg_hs;

    localparam logic [7:0] RV = 8'hA5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       fl1 = 1'b0, iv1 = 1'b0, or1 = 1'b0;
    logic [7:0] id1 = 8'h00;
    logic       rdy1, ov1;
    logic [7:0] od1;
    logic [1:0] occ1;
    logic       fl0 = 1'b0, iv0 = 1'b0, or0 = 1'b0;
    logic [7:0] id0 = 8'h00;
    logic       rdy0, ov0;
    logic [7:0] od0;
    logic [1:0] occ0;

    int   checks = 0;
    int   errors = 0;
    bit   armed  = 1'b0;
    logic [7:0] q1[$];
    logic [7:0] q0[$];
    logic [7:0] last1 = RV;
    logic [7:0] last0 = RV;

    always #5 clk = ~clk;

    pipe_reg_hs #(.WIDTH(8), .RST_VAL(RV), .SKID(1'b1)) u_skid (
        .clk(clk), .rst(rst), .flush(fl1),
        .in_valid(iv1), .in_ready(rdy1), .in_data(id1),
        .out_valid(ov1), .out_ready(or1), .out_data(od1), .occ(occ1)
    );

    pipe_reg_hs #(.WIDTH(8), .RST_VAL(RV), .SKID(1'b0)) u_noskid (
        .clk(clk), .rst(rst), .flush(fl0),
        .in_valid(iv0), .in_ready(rdy0), .in_data(id0),
        .out_valid(ov0), .out_ready(or0), .out_data(od0), .occ(occ0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive both units, check outputs mid-cycle, advance the model.
    task automatic step(input logic r,
                        input logic f1, input logic v1, input logic [7:0] d1, input logic o1,
                        input logic f0, input logic v0, input logic [7:0] d0, input logic o0);
        logic       er1, er0;
        logic [7:0] e1, e0;
        @(negedge clk);
        rst = r;
        fl1 = f1; iv1 = v1; id1 = d1; or1 = o1;
        fl0 = f0; iv0 = v0; id0 = d0; or0 = o0;
        #1;
        er1 = !r && (q1.size() < 2);
        er0 = r || (q0.size() == 0) || o0;
        if (q1.size() > 0) e1 = q1[0]; else e1 = last1;
        if (q0.size() > 0) e0 = q0[0]; else e0 = last0;
        if (armed) begin
            chk("skid_in_ready",   32'(rdy1), 32'(er1));
            chk("skid_out_valid",  32'(ov1),  32'(q1.size() > 0));
            chk("skid_out_data",   32'(od1),  32'(e1));
            chk("skid_occ",        32'(occ1), 32'(q1.size()));
            chk("noskid_in_ready", 32'(rdy0), 32'(er0));
            chk("noskid_out_valid",32'(ov0),  32'(q0.size() > 0));
            chk("noskid_out_data", 32'(od0),  32'(e0));
            chk("noskid_occ",      32'(occ0), 32'(q0.size()));
        end
        @(posedge clk);
        if (r || f1) begin
            q1.delete();
            last1 = RV;
        end else begin
            if (q1.size() > 0 && o1) last1 = q1.pop_front();
            if (v1 && er1) q1.push_back(d1);
        end
        if (r || f0) begin
            q0.delete();
            last0 = RV;
        end else begin
            if (q0.size() > 0 && o0) last0 = q0.pop_front();
            if (v0 && er0) q0.push_back(d0);
        end
        if (r) armed = 1'b1;
    endtask

    task automatic s1(input logic v, input logic [7:0] d, input logic o);
        step(1'b0, 1'b0, v, d, o, 1'b0, 1'b0, 8'h00, 1'b1);
    endtask

    task automatic s0(input logic v, input logic [7:0] d, input logic o);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, v, d, o);
    endtask

    initial begin
        // Reset then stream
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        #2;
        chk("rst_out_data", 32'(od1), 32'(RV));
        chk("rst_out_valid", 32'(ov1), 32'd0);
        chk("rst_occ", 32'(occ1), 32'd0);
        s1(1'b0, 8'h00, 1'b1);
        #2;
        chk("post_rst_ready_skid", 32'(rdy1), 32'd1);
        chk("post_rst_ready_noskid", 32'(rdy0), 32'd1);
        for (int i = 1; i <= 16; i++) begin
            s1(1'b1, 8'(i), 1'b1);
            #2;
            chk("stream_data", 32'(od1), 32'(i));
            chk("stream_occ", 32'(occ1), 32'd1);
        end
        s1(1'b0, 8'h00, 1'b1);
        #2;
        chk("stream_empty_occ", 32'(occ1), 32'd0);

        // Backpressure fill and drain
        s1(1'b1, 8'h11, 1'b0);
        s1(1'b1, 8'h22, 1'b0);
        #2;
        chk("bp_occ2", 32'(occ1), 32'd2);
        chk("bp_ready_low", 32'(rdy1), 32'd0);
        s1(1'b1, 8'h33, 1'b0);
        #2;
        chk("bp_hold_data", 32'(od1), 32'h11);
        chk("bp_hold_occ", 32'(occ1), 32'd2);
        s1(1'b1, 8'h33, 1'b1);
        #2;
        chk("bp_drain1", 32'(od1), 32'h22);
        chk("bp_ready_back", 32'(rdy1), 32'd1);
        s1(1'b1, 8'h33, 1'b1);
        #2;
        chk("bp_drain2", 32'(od1), 32'h33);
        s1(1'b0, 8'h00, 1'b1);
        #2;
        chk("bp_empty", 32'(occ1), 32'd0);

        // Non-skid combinational ready
        s0(1'b1, 8'h50, 1'b1);
        s0(1'b1, 8'h51, 1'b1);
        #2;
        chk("ns_replace_data", 32'(od0), 32'h51);
        chk("ns_replace_occ", 32'(occ0), 32'd1);
        s0(1'b1, 8'h52, 1'b0);
        #2;
        chk("ns_blocked_data", 32'(od0), 32'h51);
        s0(1'b0, 8'h00, 1'b1);

        // Flush collision in TWO
        s1(1'b1, 8'h61, 1'b0);
        s1(1'b1, 8'h62, 1'b0);
        step(1'b0, 1'b1, 1'b1, 8'h63, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        #2;
        chk("flush_occ", 32'(occ1), 32'd0);
        chk("flush_valid", 32'(ov1), 32'd0);
        chk("flush_data", 32'(od1), 32'(RV));
        s1(1'b0, 8'h00, 1'b1);
        s1(1'b0, 8'h00, 1'b1);

        // Mid-stream reset while full
        s1(1'b1, 8'h71, 1'b0);
        s1(1'b1, 8'h72, 1'b0);
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        #2;
        chk("midrst_occ", 32'(occ1), 32'd0);
        for (int i = 0; i < 4; i++) begin
            s1(1'b1, 8'(8'h40 + i), 1'b1);
            #2;
            chk("midrst_stream", 32'(od1), 32'(8'h40 + i));
        end
        s1(1'b0, 8'h00, 1'b1);

        // Random traffic on both units
        for (int i = 0; i < 10000; i++) begin
            step(1'b0,
                 ($urandom_range(99) == 0), ($urandom_range(3) != 0), 8'($urandom), 1'($urandom),
                 ($urandom_range(99) == 0), ($urandom_range(3) != 0), 8'($urandom), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
